seq_detect_scheduler: RTL and testbench
=======================================

Name: seq_detect_scheduler

Overview:
- Time-shares one 4-state "two consecutive ones" detector among NCH serial bit channels.
- Per channel, the block stores the 2-bit detector state and a saturating hit counter.
- A round-robin arbiter accepts at most one bit per cycle. The block updates that channel's state and reports a registered hit result one cycle later.
- It sits between per-lane bit sources and the status/interrupt logic.

Parameters:
- NCH, 4, number of input channels (>=2).
- CNT_W, 8, width of each per-channel saturating hit counter.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high.
- ch_valid  in  NCH  bit i: channel i presents a bit.
- ch_bit  in  NCH  bit i: data bit of channel i.
- ch_ready  out  NCH  one-hot-or-zero grant; bit accepted when valid&ready.
- ch_clr  in  NCH  bit i: synchronous clear of channel i state and counter.
- hit_valid  out  1  result strobe, one cycle after acceptance.
- hit_ch  out  $clog2(NCH)  channel index of the reported result.
- hit  out  1  1 = accepted bit drove the channel into S2.
- cnt_sel  in  $clog2(NCH)  counter read select.
- cnt_val  out  CNT_W  combinational read of counter[cnt_sel]; 0 if cnt_sel>=NCH.

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Detector encoding: S0=00, S1=01, S2=10, S3=11.
- Transitions when bit=1: S0->S1, S1->S2, S2->S3, S3->S3.
- Transitions when bit=0: any state -> S0.
- hit = (next state == S2). Hit fires only on the second consecutive 1 after a 0, reset or clear. S3 gives no hit.
- Eligibility: channel i is eligible when ch_valid[i] & ~ch_clr[i].
- Arbitration: round-robin pointer ptr. Grant goes to the first eligible channel at or after ptr, with wrap NCH-1 -> 0.
- ch_ready is combinational from ch_valid, ch_clr and ptr. It is never asserted for an ineligible channel and has at most one bit set.
- On acceptance (posedge with a grant to g):
  - state[g] <= next state.
  - counter[g] increments if hit; it saturates at 2^CNT_W-1 with no wrap.
  - ptr <= (g+1) mod NCH.
  - hit_valid <= 1, hit_ch <= g, hit <= computed hit.
- No acceptance: hit_valid <= 0; hit_ch and hit hold their last values; ptr holds.
- Latency: state update and counter update at the accept edge; result visible one cycle after acceptance. Back-to-back accepts give one result per cycle.
- ch_clr[i] at posedge: state[i] <= S0, counter[i] <= 0. Clear has priority over any update; a clearing channel is never granted that cycle.
- Channels not granted keep their state unchanged regardless of ch_bit.
- cnt_val reflects the registered counter value (pre-update in the accept cycle).
- Reset (async, any time, including mid-stream):
  - All states S0, counters 0, ptr 0.
  - hit_valid 0, hit_ch 0, hit 0.
  - ch_ready is 0 while rst is high.
  - After release, the first grant searches from channel 0.

Test Plan:
- Single channel: ch0 sends 1,1,1,0,1,1 on consecutive cycles, others idle. Expect ch_ready[0]=1 each cycle; hit_valid every cycle after the first; hit=0,1,0,0,0,1; hit_ch=0; cnt_val(sel=0)=2.
- Fairness: all 4 channels valid continuously from reset. Grants go 0,1,2,3,0,1..., one per cycle, and each channel is ready exactly 1 cycle in 4.
- State isolation: cycle sequence ch0 bit1, ch1 bit1, ch1 bit1, ch0 bit1. Expect hits 0,0,1,1 with hit_ch 0,1,1,0; counters ch0=1, ch1=1.
- Clear collision: ch2 in S1; assert ch_clr[2] with ch_valid[2]=1. Expect ch_ready[2]=0 and counter[2]=0. A following bit 1 gives hit=0 (S1), and the next bit 1 gives hit=1.
- Saturation with CNT_W=2: drive ch1 pattern 0,1,1 five times. Expect counter[1]=3 after the 3rd hit and 3 after the 5th.
- Async reset: assert rst mid-stream between edges with ch1 in S2 and ptr=2. Expect hit_valid=0, ch_ready=0 and cnt_val=0 immediately. After release, all channels valid: first grant to ch0; ch1 bit 1 gives hit=0.

Source files
------------

// File: rtl/seq_detect_scheduler_if.sv
// Bit-channel handshake, detector result strobe and counter read port of seq_detect_scheduler.
// master = bit sources / status logic, slave = the scheduler.
interface seq_detect_scheduler_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
);
  localparam int IW = $clog2(NCH);

  logic [NCH-1:0]   ch_valid;
  logic [NCH-1:0]   ch_bit;
  logic [NCH-1:0]   ch_ready;
  logic [NCH-1:0]   ch_clr;
  logic             hit_valid;
  logic [IW-1:0]    hit_ch;
  logic             hit;
  logic [IW-1:0]    cnt_sel;
  logic [CNT_W-1:0] cnt_val;

  modport master (
    output ch_valid, ch_bit, ch_clr, cnt_sel,
    input  ch_ready, hit_valid, hit_ch, hit, cnt_val
  );

  modport slave (
    input  ch_valid, ch_bit, ch_clr, cnt_sel,
    output ch_ready, hit_valid, hit_ch, hit, cnt_val
  );
endinterface

// File: rtl/seq_detect_scheduler.sv
// Round-robin time-shared "two consecutive ones" detector over NCH bit channels; result one cycle after accept.
// At most one bit accepted per cycle via one-hot ch_ready; clearing channels are never granted.
module seq_detect_scheduler #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_detect_scheduler_if.slave bus
);
  localparam int IW = $clog2(NCH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } det_state_t;

  det_state_t       st  [NCH];
  logic [CNT_W-1:0] cnt [NCH];
  logic [IW-1:0]    ptr;

  logic [NCH-1:0]   elig;
  logic             grant_vld;
  logic [IW-1:0]    grant_idx;
  det_state_t       cur_st;
  det_state_t       nxt_st;
  logic             nxt_hit;

  assign elig = bus.ch_valid & ~bus.ch_clr;

  // First eligible channel at or after ptr, wrapping; nothing is granted while in reset.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!grant_vld && elig[(int'(ptr) + k) % NCH]) begin
        grant_vld = 1'b1;
        grant_idx = IW'((int'(ptr) + k) % NCH);
      end
    end
    if (rst) begin
      grant_vld = 1'b0;
    end
  end

  always_comb begin
    bus.ch_ready = '0;
    if (grant_vld) begin
      bus.ch_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    cur_st = st[grant_idx];
    nxt_st = S0;
    if (bus.ch_bit[grant_idx]) begin
      case (cur_st)
        S0:      nxt_st = S1;
        S1:      nxt_st = S2;
        default: nxt_st = S3;
      endcase
    end
    nxt_hit = (nxt_st == S2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        st[i]  <= S0;
        cnt[i] <= '0;
      end
      ptr           <= '0;
      bus.hit_valid <= 1'b0;
      bus.hit_ch    <= '0;
      bus.hit       <= 1'b0;
    end else begin
      bus.hit_valid <= grant_vld;
      if (grant_vld) begin
        st[grant_idx] <= nxt_st;
        if (nxt_hit && cnt[grant_idx] != CNT_MAX) begin
          cnt[grant_idx] <= cnt[grant_idx] + CNT_W'(1);
        end
        ptr        <= (int'(grant_idx) == NCH - 1) ? '0 : grant_idx + IW'(1);
        bus.hit_ch <= grant_idx;
        bus.hit    <= nxt_hit;
      end
      // A clearing channel is never granted, so this cannot collide with the update above.
      for (int i = 0; i < NCH; i++) begin
        if (bus.ch_clr[i]) begin
          st[i]  <= S0;
          cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    bus.cnt_val = '0;
    if (int'(bus.cnt_sel) < NCH) begin
      bus.cnt_val = cnt[bus.cnt_sel];
    end
  end
endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench for seq_detect_scheduler (NCH=4, CNT_W=2) with a run-length reference model checked every cycle.
module tb_seq_detect_scheduler;
  localparam int NCH   = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  seq_detect_scheduler_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

  seq_detect_scheduler #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per channel the length of the current run of ones, and the hit count.
  int m_run [NCH];
  int m_cnt [NCH];
  int m_ptr;
  int m_hv, m_hc, m_hit;

  int hq_ch[$];
  int hq_hit[$];
  logic [NCH-1:0] last_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 0;
      m_cnt[i] = 0;
    end
    m_ptr = 0;
    m_hv  = 0;
    m_hc  = 0;
    m_hit = 0;
  endtask

  // Compare process: check at negedge, commit the model at the following posedge.
  initial begin
    int g, pb, exp_ready, sel;
    logic [NCH-1:0] pclr;
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
        chk("rst ch_ready", bus.ch_ready, 0);
        chk("rst hit_valid", bus.hit_valid, 0);
        chk("rst hit_ch", bus.hit_ch, 0);
        chk("rst hit", bus.hit, 0);
        chk("rst cnt_val", bus.cnt_val, 0);
      end else begin
        g = -1;
        for (int k = 0; k < NCH; k++) begin
          int j;
          j = (m_ptr + k) % NCH;
          if (g < 0 && bus.ch_valid[j] && !bus.ch_clr[j]) g = j;
        end
        exp_ready = (g >= 0) ? (1 << g) : 0;
        chk("ch_ready", bus.ch_ready, exp_ready);
        chk("hit_valid", bus.hit_valid, m_hv);
        if (m_hv != 0) begin
          chk("hit_ch", bus.hit_ch, m_hc);
          chk("hit", bus.hit, m_hit);
        end
        sel = int'(bus.cnt_sel);
        chk("cnt_val", bus.cnt_val, m_cnt[sel]);
        if (bus.hit_valid === 1'b1) begin
          hq_ch.push_back(int'(bus.hit_ch));
          hq_hit.push_back(int'(bus.hit));
        end
        pb   = (g >= 0) ? int'(bus.ch_bit[g]) : 0;
        pclr = bus.ch_clr;
        @(posedge clk);
        if (!rst) begin
          m_hv = (g >= 0) ? 1 : 0;
          for (int i = 0; i < NCH; i++) begin
            if (pclr[i]) begin
              m_run[i] = 0;
              m_cnt[i] = 0;
            end
          end
          if (g >= 0) begin
            m_run[g] = pb ? ((m_run[g] < 3) ? m_run[g] + 1 : 3) : 0;
            m_hit    = (m_run[g] == 2) ? 1 : 0;
            if (m_hit != 0 && m_cnt[g] < CMAX) m_cnt[g]++;
            m_hc  = g;
            m_ptr = (g + 1) % NCH;
          end
        end
      end
    end
  end

  task automatic step(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                      input logic [NCH-1:0] c, input int sel);
    bus.ch_valid = v;
    bus.ch_bit   = b;
    bus.ch_clr   = c;
    bus.cnt_sel  = 2'(sel);
    #1 last_ready = bus.ch_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_cnt(input string name, input int sel, input int exp);
    bus.cnt_sel = 2'(sel);
    #1 chk(name, bus.cnt_val, exp);
  endtask

  task automatic do_reset();
    bus.ch_valid = '0;
    bus.ch_bit   = '0;
    bus.ch_clr   = '0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    hq_ch.delete();
    hq_hit.delete();
  endtask

  task automatic chk_seq(input string name, input int n, input int ech[8], input int eh[8]);
    chk($sformatf("%s count", name), hq_ch.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < hq_ch.size()) begin
        chk($sformatf("%s ch[%0d]", name, i), hq_ch[i], ech[i]);
        chk($sformatf("%s hit[%0d]", name, i), hq_hit[i], eh[i]);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.ch_valid = '0;
    bus.ch_bit   = '0;
    bus.ch_clr   = '0;
    bus.cnt_sel  = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single channel: 1,1,1,0,1,1 on ch0.
    step(4'b0001, 4'b0001, 4'b0000, 0);
    chk("single ready0", last_ready, 4'b0001);
    step(4'b0001, 4'b0001, 4'b0000, 0);
    step(4'b0001, 4'b0001, 4'b0000, 0);
    step(4'b0001, 4'b0000, 4'b0000, 0);
    step(4'b0001, 4'b0001, 4'b0000, 0);
    step(4'b0001, 4'b0001, 4'b0000, 0);
    step(4'b0000, 4'b0000, 4'b0000, 0);
    chk_seq("single", 6, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 1, 0, 0, 0, 1, 0, 0});
    rd_cnt("single cnt0", 0, 2);

    // Fairness: all channels valid from reset.
    do_reset();
    for (int i = 0; i < 8; i++) step(4'b1111, 4'b0000, 4'b0000, i % NCH);
    step(4'b0000, 4'b0000, 4'b0000, 0);
    chk_seq("fair", 8, '{0, 1, 2, 3, 0, 1, 2, 3}, '{0, 0, 0, 0, 0, 0, 0, 0});

    // State isolation between ch0 and ch1.
    do_reset();
    step(4'b0001, 4'b0001, 4'b0000, 0);
    step(4'b0010, 4'b0010, 4'b0000, 0);
    step(4'b0010, 4'b0010, 4'b0000, 0);
    step(4'b0001, 4'b0001, 4'b0000, 0);
    step(4'b0000, 4'b0000, 4'b0000, 0);
    chk_seq("iso", 4, '{0, 1, 1, 0, 0, 0, 0, 0}, '{0, 0, 1, 1, 0, 0, 0, 0});
    rd_cnt("iso cnt0", 0, 1);
    rd_cnt("iso cnt1", 1, 1);

    // Clear colliding with a valid bit on ch2.
    do_reset();
    step(4'b0100, 4'b0100, 4'b0000, 2);
    step(4'b0100, 4'b0100, 4'b0000, 2);
    step(4'b0100, 4'b0000, 4'b0000, 2);
    step(4'b0100, 4'b0100, 4'b0000, 2);
    rd_cnt("clr cnt2 before", 2, 1);
    step(4'b0100, 4'b0100, 4'b0100, 2);
    chk("clr ready", last_ready, 4'b0000);
    rd_cnt("clr cnt2 after", 2, 0);
    step(4'b0100, 4'b0100, 4'b0000, 2);
    step(4'b0100, 4'b0100, 4'b0000, 2);
    step(4'b0000, 4'b0000, 4'b0000, 2);
    chk_seq("clr", 6, '{2, 2, 2, 2, 2, 2, 0, 0}, '{0, 1, 0, 0, 0, 1, 0, 0});

    // Counter saturation on ch1 with pattern 0,1,1.
    do_reset();
    for (int r = 1; r <= 5; r++) begin
      step(4'b0010, 4'b0000, 4'b0000, 1);
      step(4'b0010, 4'b0010, 4'b0000, 1);
      step(4'b0010, 4'b0010, 4'b0000, 1);
      if (r == 2) rd_cnt("sat cnt after 2", 1, 2);
      if (r == 3) rd_cnt("sat cnt after 3", 1, 3);
      if (r == 5) rd_cnt("sat cnt after 5", 1, 3);
    end
    step(4'b0000, 4'b0000, 4'b0000, 1);

    // Asynchronous reset between edges with ch1 in S2 and ptr=2.
    do_reset();
    step(4'b0010, 4'b0010, 4'b0000, 1);
    step(4'b0010, 4'b0010, 4'b0000, 1);
    bus.ch_valid = 4'b1111;
    bus.ch_bit   = 4'b1111;
    bus.cnt_sel  = 2'd1;
    #1 chk("pre-rst cnt1", bus.cnt_val, 1);
    chk("pre-rst hit_valid", bus.hit_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("async hit_valid", bus.hit_valid, 0);
    chk("async ch_ready", bus.ch_ready, 0);
    chk("async cnt_val", bus.cnt_val, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    hq_ch.delete();
    hq_hit.delete();
    step(4'b1111, 4'b1111, 4'b0000, 1);
    chk("post-rst first grant", last_ready, 4'b0001);
    step(4'b1111, 4'b1111, 4'b0000, 1);
    step(4'b0000, 4'b0000, 4'b0000, 1);
    chk_seq("post-rst", 2, '{0, 1, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
